// File: rtl/cs_window.sv
// Sliding-window approximation filter: keeps the last DEPTH samples, picks the
// floor/ceiling neighbour of the window average and emits (sum + DEPTH*Xappr)/(DEPTH-1).
module cs_window #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic             mode,
  output logic [WIDTH+1:0] Y,
  output logic             out_valid
);

  localparam int SUM_W = WIDTH + $clog2(DEPTH);
  localparam int ACC_W = SUM_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SHIFT = $clog2(DEPTH - 1);
  localparam int Y_W   = WIDTH + 2;

  if (DEPTH < 3 || ((DEPTH - 1) & (DEPTH - 2)) != 0) begin : g_bad_depth
    $error("cs_window: DEPTH-1 must be a power of two");
  end
  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("cs_window: WIDTH must be in 4..16");
  end

  logic [WIDTH-1:0] win_q [DEPTH];
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q;
  logic [ACC_W-1:0] scaled [DEPTH];
  logic [ACC_W-1:0] sum_ext;
  logic [WIDTH-1:0] xappr;
  logic [Y_W-1:0]   y_q, y_d;
  logic             out_valid_q;

  // Stage-1 next state; the saturating counter keeps s1_valid high once full.
  always_comb begin
    sum_d      = sum_q + SUM_W'(X) - SUM_W'(win_q[DEPTH-1]);
    cnt_d      = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
    s1_valid_d = (cnt_d == CNT_W'(DEPTH));
  end

  // NOTE: the window is reset and flushed to zero because the running sum
  // subtracts the outgoing tap; stale contents would corrupt the sum on refill.
  // NOTE: all state uses non-blocking assignment so every shift stage reads
  // the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
    end else if (in_valid) begin
      win_q[0] <= X;
      for (int i = 1; i < DEPTH; i++) win_q[i] <= win_q[i-1];
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= mode;
    end else begin
      s1_valid_q <= 1'b0;
    end
  end

  // DEPTH*win[i] vs sum replaces a divide by DEPTH.
  assign sum_ext = ACC_W'(sum_q);
  for (genvar g = 0; g < DEPTH; g++) begin : g_scale
    assign scaled[g] = ACC_W'(DEPTH) * ACC_W'(win_q[g]);
  end

  // NOTE: xappr and y_d get a value before the loop so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    xappr = s1_mode_q ? '1 : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (s1_mode_q) begin
        if (scaled[i] >= sum_ext && win_q[i] < xappr) xappr = win_q[i];
      end else begin
        if (scaled[i] <= sum_ext && win_q[i] > xappr) xappr = win_q[i];
      end
    end
    y_d = Y_W'((sum_ext + ACC_W'(DEPTH) * ACC_W'(xappr)) >> SHIFT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) y_q <= y_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cs_window.sv
// Directed and model-based checks for cs_window at WIDTH=8, DEPTH=9.
module tb_cs_window;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] X = '0;
  logic       mode = 1'b0;
  logic [9:0] Y;
  logic       out_valid;

  int n_pass = 0;
  int n_total = 0;

  cs_window #(.WIDTH(8), .DEPTH(9)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .X(X), .mode(mode), .Y(Y), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs read right after reflect the
  // state registered at the preceding rising edge.
  task automatic step(input logic v, input logic [7:0] x, input logic m, input logic f);
    @(negedge clk);
    in_valid = v; X = x; mode = m; flush = f;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_run(input logic [7:0] val, input int n, input logic m);
    for (int i = 0; i < n; i++) step(1'b1, val, m, 1'b0);
  endtask

  task automatic expect_out(input string name, input logic ov, input logic [9:0] y);
    n_total++;
    if (out_valid !== ov || Y !== y)
      $display("FAIL %s: out_valid=%b Y=%h, expected out_valid=%b Y=%h", name, out_valid, Y, ov, y);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    n_total++;
    if (Y !== 10'h000) $display("FAIL reset_y: Y=%h expected 000", Y); else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_ov: out_valid=%b expected 0", out_valid); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b0);
      if (k >= 2) begin
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL fill_early[%0d]: out_valid=%b expected 0", k, out_valid);
        else n_pass++;
      end
    end
    idle();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL fill_ninth_lat: out_valid=%b expected 0", out_valid); else n_pass++;
    idle();
    expect_out("fill_1to9", 1'b1, 10'h00B);  // (45 + 9*5) >> 3
  endtask

  task automatic test_gap();
    idle();
    expect_out("gap_hold_a", 1'b0, 10'h00B);
    idle();
    expect_out("gap_hold_b", 1'b0, 10'h00B);
    step(1'b1, 8'd10, 1'b0, 1'b0);
    idle();
    expect_out("gap_latency", 1'b0, 10'h00B);
    idle();
    expect_out("gap_2to10", 1'b1, 10'h00D);  // (54 + 9*6) >> 3
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'd11, 1'b0, 1'b0);
    step(1'b1, 8'd12, 1'b0, 1'b0);
    step(1'b1, 8'd13, 1'b0, 1'b0);
    expect_out("b2b_3to11", 1'b1, 10'h00F);   // (63 + 63) >> 3
    idle();
    expect_out("b2b_4to12", 1'b1, 10'h012);   // (72 + 72) >> 3
    idle();
    expect_out("b2b_5to13", 1'b1, 10'h014);   // (81 + 81) >> 3
    idle();
    expect_out("b2b_drain", 1'b0, 10'h014);
  endtask

  task automatic test_mode();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    expect_out("flush_keeps_y", 1'b0, 10'h014);
    send_run(8'h00, 8, 1'b0);
    step(1'b1, 8'd10, 1'b0, 1'b0);
    idle(); idle();
    expect_out("mode_floor", 1'b1, 10'h001);  // Xappr 0: 10 >> 3
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send_run(8'h00, 8, 1'b1);
    step(1'b1, 8'd10, 1'b1, 1'b0);
    idle(); idle();
    expect_out("mode_ceil", 1'b1, 10'h00C);   // Xappr 10: 100 >> 3
  endtask

  task automatic test_saturation();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send_run(8'hFF, 9, 1'b0);
    idle(); idle();
    expect_out("sat_floor", 1'b1, 10'h23D);   // 4590 >> 3
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    idle(); idle();
    expect_out("sat_ceil", 1'b1, 10'h23D);
  endtask

  task automatic test_flush();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send_run(8'h20, 9, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);  // flush one cycle behind the 9th sample
    idle();
    expect_out("flush_completes", 1'b1, 10'h048);
    idle();
    expect_out("flush_no_more", 1'b0, 10'h048);
    step(1'b1, 8'h50, 1'b0, 1'b1);  // collision: sample must be dropped
    send_run(8'h20, 8, 1'b0);
    idle();
    expect_out("collide_drop_a", 1'b0, 10'h048);
    idle();
    expect_out("collide_drop_b", 1'b0, 10'h048);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    idle(); idle();
    expect_out("collide_refill", 1'b1, 10'h048);
  endtask

  task automatic test_async_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send_run(8'h07, 9, 1'b1);
    step(1'b1, 8'h07, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 10'h000);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    send_run(8'h07, 8, 1'b1);
    idle(); idle();
    expect_out("reset_refill", 1'b0, 10'h000);
    step(1'b1, 8'h07, 1'b1, 1'b0);
    idle(); idle();
    expect_out("reset_full", 1'b1, 10'h00F);  // (63 + 63) >> 3
  endtask

  task automatic test_random();
    int   mw [9];
    int   cnt, sum, xa, my;
    logic p1_v, p2_v, nv, v, m;
    int   p1_y, p2_y, ny;
    logic [7:0] x;
    for (int i = 0; i < 9; i++) mw[i] = 0;
    cnt = 0; sum = 0; my = 0;
    p1_v = 1'b0; p2_v = 1'b0; p1_y = 0; p2_y = 0;
    @(negedge clk); reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 2002; k++) begin
      v = (k < 2000) && ($urandom_range(0, 4) != 0);
      x = 8'($urandom_range(0, 255));
      m = 1'($urandom_range(0, 1));
      step(v, x, m, 1'b0);
      if (p2_v) my = p2_y;
      n_total++;
      if (Y !== 10'(my) || out_valid !== p2_v)
        $display("FAIL random[%0d]: out_valid=%b Y=%h, expected out_valid=%b Y=%h",
                 k, out_valid, Y, p2_v, 10'(my));
      else n_pass++;
      nv = 1'b0; ny = 0;
      if (v) begin
        sum = sum + int'(x) - mw[8];
        for (int i = 8; i > 0; i--) mw[i] = mw[i-1];
        mw[0] = int'(x);
        if (cnt < 9) cnt++;
        if (cnt == 9) begin
          nv = 1'b1;
          if (m) begin
            xa = 255;
            for (int i = 0; i < 9; i++) if (mw[i] >= (sum + 8) / 9 && mw[i] < xa) xa = mw[i];
          end else begin
            xa = 0;
            for (int i = 0; i < 9; i++) if (mw[i] <= sum / 9 && mw[i] > xa) xa = mw[i];
          end
          ny = (sum + 9 * xa) / 8;
        end
      end
      p2_v = p1_v; p2_y = p1_y;
      p1_v = nv;   p1_y = ny;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gap();
    test_back_to_back();
    test_mode();
    test_saturation();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
